// File: rtl/demux_pkg.sv
// Shared constants and FSM encoding for the serial-to-bank demux.
package demux_pkg;

  localparam int SEL_W_DEF = 9;
  localparam int OUT_W_DEF = 2 ** SEL_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/dec_onehot.sv
// Combinational binary-to-one-hot decoder; bit k is set when idx == k.
module dec_onehot #(
  parameter int SEL_W = 9
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [2**SEL_W-1:0]   onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/demux_512x1_seq.sv
// Steers a serial bit stream into a registered bit bank, single writes or auto-increment bursts.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | accepts single beats at sel, or the first beat of a burst
//   ST_BURST | accepts beats at the internal address, sel ignored
//   ST_DONE  | one-cycle frame_done pulse, no beat accepted
module demux_512x1_seq
  import demux_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 burst_start,
  input  logic [SEL_W:0]       burst_len,
  output logic [2**SEL_W-1:0]  out,
  output logic [2**SEL_W-1:0]  wr_strobe,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int N = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] ONE_A   = {{(SEL_W-1){1'b0}}, 1'b1};
  localparam logic [SEL_W:0]   ONE_C   = {{SEL_W{1'b0}}, 1'b1};
  localparam logic [SEL_W:0]   LEN_MAX = {1'b1, {SEL_W{1'b0}}};

  state_t           state, state_nx;
  logic [SEL_W-1:0] addr, addr_nx;
  logic [SEL_W:0]   cnt, cnt_nx;
  logic [SEL_W:0]   len_eff;
  logic [SEL_W-1:0] wr_idx;
  logic [N-1:0]     dec;
  logic [N-1:0]     we;
  logic             accept;

  assign in_ready   = rst_n && (state != ST_DONE);
  assign accept     = in_valid && in_ready;
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);
  assign len_eff    = (burst_len == '0) ? LEN_MAX : burst_len;

  // cnt holds beats still owed after the current one; terminal count is 1
  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    cnt_nx   = cnt;
    wr_idx   = sel;
    case (state)
      ST_IDLE: begin
        if (accept && burst_start) begin
          addr_nx  = sel + ONE_A;
          cnt_nx   = len_eff - ONE_C;
          state_nx = (len_eff == ONE_C) ? ST_DONE : ST_BURST;
        end
      end
      ST_BURST: begin
        wr_idx = addr;
        if (accept) begin
          addr_nx = addr + ONE_A;
          cnt_nx  = cnt - ONE_C;
          if (cnt == ONE_C) state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  dec_onehot #(.SEL_W(SEL_W)) u_dec (
    .idx    (wr_idx),
    .onehot (dec)
  );

  assign we = dec & {N{accept}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      cnt       <= '0;
      out       <= '0;
      wr_strobe <= '0;
    end else begin
      state     <= state_nx;
      addr      <= addr_nx;
      cnt       <= cnt_nx;
      out       <= (out & ~we) | (we & {N{din}});
      wr_strobe <= we;
    end
  end

endmodule

// File: tb/tb_demux_512x1_seq.sv
// Self-checking bench: behavioural model plus write scoreboard, table vectors and burst corner cases.
module tb_demux_512x1_seq;
  import demux_pkg::*;

  localparam int SW = SEL_W_DEF;
  localparam int N  = OUT_W_DEF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          din;
  logic [SW-1:0] sel;
  logic          in_valid;
  logic          in_ready;
  logic          burst_start;
  logic [SW:0]   burst_len;
  logic [N-1:0]  out;
  logic [N-1:0]  wr_strobe;
  logic          frame_done;
  logic          busy;

  demux_512x1_seq #(.SEL_W(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .sel         (sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .out         (out),
    .wr_strobe   (wr_strobe),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int fd_count = 0;

  always @(negedge clk) if (frame_done) fd_count++;

  // reference model
  logic [N-1:0] m_out;
  int m_state, m_addr, m_left;
  int sb_q[$];

  typedef struct {
    bit v;
    int s;
    bit d;
    bit exp_bit;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out   = '0;
    m_state = 0;
    m_addr  = 0;
    m_left  = 0;
    sb_q.delete();
  endtask

  // drive one cycle, advance the model, then check every output after the edge
  task automatic cycle(input bit v, input bit bs, input int s, input int len, input bit d);
    int widx, L, idx;
    logic [N-1:0] exp_strobe;
    in_valid = v; burst_start = bs; sel = s[SW-1:0]; burst_len = len[SW:0]; din = d;
    widx = -1;
    case (m_state)
      0: if (v) begin
        widx = s % N;
        if (bs) begin
          L = (len == 0) ? N : len;
          m_left  = L - 1;
          m_addr  = (s + 1) % N;
          m_state = (L == 1) ? 2 : 1;
        end
      end
      1: if (v) begin
        widx   = m_addr;
        m_addr = (m_addr + 1) % N;
        m_left--;
        if (m_left == 0) m_state = 2;
      end
      default: m_state = 0;
    endcase
    if (widx >= 0) m_out[widx] = d;
    sb_q.push_back(widx);
    @(posedge clk); #1;
    idx = sb_q.pop_front();
    exp_strobe = '0;
    if (idx >= 0) exp_strobe[idx] = 1'b1;
    chk("out_bank", out, m_out);
    chk("wr_strobe", wr_strobe, exp_strobe);
    chk("frame_done", {{(N-1){1'b0}}, frame_done}, {{(N-1){1'b0}}, (m_state == 2)});
    chk("busy", {{(N-1){1'b0}}, busy}, {{(N-1){1'b0}}, (m_state != 0)});
    chk("in_ready", {{(N-1){1'b0}}, in_ready}, {{(N-1){1'b0}}, (m_state != 2)});
  endtask

  task automatic chk_bit(input string name, input int k, input bit exp);
    chk(name, {{(N-1){1'b0}}, out[k]}, {{(N-1){1'b0}}, exp});
  endtask

  initial begin
    int fd0;
    vecs[0] = '{1, 300, 1, 1};
    vecs[1] = '{1, 0,   1, 1};
    vecs[2] = '{1, 511, 1, 1};
    vecs[3] = '{0, 5,   1, 0};
    vecs[4] = '{1, 300, 0, 0};
    vecs[5] = '{1, 1,   1, 1};

    rst_n = 1'b0; din = 1'b0; sel = '0; in_valid = 1'b0; burst_start = 1'b0; burst_len = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out, '0);
    chk("rst_strobe", wr_strobe, '0);
    chk("rst_ready", {{(N-1){1'b0}}, in_ready}, '0);
    chk("rst_busy", {{(N-1){1'b0}}, busy}, '0);
    chk("rst_fd", {{(N-1){1'b0}}, frame_done}, '0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {{(N-1){1'b0}}, in_ready}, {{(N-1){1'b0}}, 1'b1});
    @(posedge clk); #1;

    // single writes from the table; first entry lands on a cleared bank
    for (int i = 0; i < 6; i++) begin
      cycle(vecs[i].v, 1'b0, vecs[i].s, 0, vecs[i].d);
      chk_bit("vec_bit", vecs[i].s, vecs[i].exp_bit);
      if (i == 0) begin
        logic [N-1:0] one300;
        one300 = '0; one300[300] = 1'b1;
        chk("single_300_bank", out, one300);
        chk("single_300_strobe", wr_strobe, one300);
      end
    end
    cycle(0, 0, 0, 0, 0);

    // burst wrapping past the top index
    fd0 = fd_count;
    cycle(1, 1, 510, 4, 1);
    cycle(1, 0, 3, 0, 0);
    cycle(1, 0, 3, 0, 1);
    cycle(1, 0, 3, 0, 1);
    chk_bit("wrap_510", 510, 1);
    chk_bit("wrap_511", 511, 0);
    chk_bit("wrap_0", 0, 1);
    chk_bit("wrap_1", 1, 1);
    cycle(0, 0, 0, 0, 0);
    chk("wrap_fd_count", N'(fd_count - fd0), N'(1));

    // stall mid-burst
    fd0 = fd_count;
    cycle(1, 1, 20, 3, 1);
    cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 99, 0, 0);
    chk_bit("stall_22_held", 22, 0);
    cycle(1, 0, 0, 0, 1);
    chk_bit("stall_22", 22, 1);
    cycle(0, 0, 0, 0, 0);
    chk("stall_fd_count", N'(fd_count - fd0), N'(1));

    // burst_start during a burst is ignored
    cycle(1, 1, 100, 4, 1);
    cycle(1, 1, 7, 2, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    chk_bit("ignore_7", 7, 0);
    chk_bit("ignore_103", 103, 1);
    cycle(0, 0, 0, 0, 0);

    // reset abandons a burst
    fd0 = fd_count;
    cycle(1, 1, 200, 8, 1);
    cycle(1, 0, 0, 0, 1);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst_mid_out", out, '0);
    chk("rst_mid_busy", {{(N-1){1'b0}}, busy}, '0);
    chk("rst_mid_ready", {{(N-1){1'b0}}, in_ready}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_mid_ready_rel", {{(N-1){1'b0}}, in_ready}, {{(N-1){1'b0}}, 1'b1});
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    chk("rst_mid_fd_count", N'(fd_count - fd0), '0);

    // full 512-beat frame with burst_len 0
    fd0 = fd_count;
    cycle(1, 1, 0, 0, 1);
    for (int k = 2; k <= N; k++) cycle(1, 0, 0, 0, (k % 2) == 1);
    chk("frame_pattern", out, {128{4'h5}});
    chk("frame_fd_before_done", N'(fd_count - fd0), '0);
    cycle(0, 0, 0, 0, 0);
    chk("frame_fd_count", N'(fd_count - fd0), N'(1));
    cycle(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_512x1_seq.md
DEMUX_512X1_SEQ -- requirements
Module: demux_512x1_seq

Interface
REQ-001 SHALL have parameter SEL_W, default 9, meaning select width; output width is 2**SEL_W.
REQ-002 SHALL have port clk  input  1  sole clock; all flops rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port din  input  1  serial data bit to steer.
REQ-005 SHALL have port sel  input  SEL_W  target index (single mode) or base index (burst start).
REQ-006 SHALL have port in_valid  input  1  din/sel qualify this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port burst_start  input  1  begin auto-increment burst at sel.
REQ-009 SHALL have port burst_len  input  SEL_W+1  beats in burst, 1..512; 0 treated as 512.
REQ-010 SHALL have port out  output  2**SEL_W  registered bit bank.
REQ-011 SHALL have port wr_strobe  output  2**SEL_W  one-hot, bit written in previous cycle.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse after last burst beat lands.
REQ-013 SHALL have port busy  output  1  high while in BURST or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, BURST, DONE.
REQ-015 In IDLE, in_ready SHALL be 1; a beat (in_valid & in_ready & !burst_start) SHALL write out[sel] <= din at that clock edge.
REQ-016 In IDLE, burst_start & in_valid SHALL load addr counter with sel, beat counter with burst_len, write din to out[sel] as beat 1, go to BURST (or DONE if length 1).
REQ-017 In BURST, sel SHALL be ignored; each accepted beat writes out[addr], addr increments modulo 2**SEL_W (511 wraps to 0), beat counter decrements.
REQ-018 Acceptance of the final burst beat SHALL transition BURST -> DONE.
REQ-019 In DONE, in_ready SHALL be 0, frame_done SHALL be 1 for exactly that cycle, then FSM returns to IDLE.
REQ-020 burst_start asserted while in BURST or DONE SHALL be ignored.
REQ-021 in_valid low SHALL stall without state change; no bit of out changes.
REQ-022 Unaddressed out bits SHALL hold value; exactly one out bit changes per accepted beat.
REQ-023 wr_strobe SHALL be registered one-hot of the written index, one cycle after the write; all-zero otherwise.
REQ-024 Write latency: out[k] SHALL reflect din one clock after the accepting edge.
REQ-025 Selection SHALL match the mux convention: index k corresponds to sel == k, with sel[0] LSB.

Reset
REQ-026 On rst_n low, asynchronously: out = 0, wr_strobe = 0, frame_done = 0, busy = 0, FSM = IDLE, counters = 0.
REQ-027 in_ready SHALL be 0 during reset and 1 in the first cycle after release.
REQ-028 Reset mid-burst SHALL abandon the burst; no frame_done is emitted.

Structure
REQ-029 A shared package demux_pkg SHALL hold SEL_W default, derived width constant, and the FSM state encoding.
REQ-030 One sub-module, dec_onehot (SEL_W-to-2**SEL_W one-hot decoder, combinational), SHALL generate write enables and the wr_strobe source.
REQ-031 Target size: 120-400 lines of RTL; no memories, flop bank only.

Verification
REQ-032 Single write: IDLE, sel=9'd300, din=1, in_valid=1 for one cycle -> out[300]=1 next cycle, wr_strobe one-hot at bit 300, all other out bits 0.
REQ-033 Burst with wrap: sel=510, burst_len=4, din=1,0,1,1 -> out[510]=1, out[511]=0, out[0]=1, out[1]=1; frame_done pulses once; busy falls with the return to IDLE.
REQ-034 Stall: burst_len=3 with in_valid low for 5 cycles mid-burst -> addr holds, no out change, burst completes after remaining beats.
REQ-035 Reset mid-burst: rst_n low after 2 of 8 beats -> out all 0 immediately, FSM IDLE, no frame_done pulse.
REQ-036 Full frame: burst_len=0, sel=0, 512 alternating beats -> out = 512'h5555...5 (din starts at 1), frame_done pulses once after beat 512.
REQ-037 Ignore: burst_start during BURST with a different sel -> burst continues at the internal addr, no restart.
